// File: rtl/cpu7_intr_ctl.sv
// Interrupt controller: synchronizes the external line, masks pending sources,
// and sequences IDLE/ARM/TAKEN so at most one interrupt is taken per enable window.
module cpu7_intr_ctl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ext_intr,
    input  logic       csr_ecl_timer_intr,
    input  logic [1:0] estat_sis,
    input  logic       csr_ecl_crmd_ie,
    input  logic [3:0] ecfg_lie,
    input  logic       valid_e,
    input  logic       except_e,
    input  logic       ertn_e,
    output logic       intr_take,
    output logic [1:0] intr_src,
    output logic [3:0] intr_pend
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_TAKEN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_src;
    logic [3:0]             w_pend;
    logic [3:0]             w_act;
    logic                   w_any_pend;
    logic [1:0]             w_win;
    logic                   w_take;

    // Fixed priority: ext > timer > swi1 > swi0.
    function automatic logic [1:0] f_prio(input logic [3:0] act);
        logic [1:0] sel;
        casez (act)
            4'b1???: sel = 2'd3;
            4'b01??: sel = 2'd2;
            4'b001?: sel = 2'd1;
            4'b0001: sel = 2'd0;
            default: sel = 2'd0;
        endcase
        return sel;
    endfunction

    // External interrupt synchronizer chain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ext_intr};
        end
    end

    // Pending is forced to zero while reset is held, since timer/swi feed through.
    assign w_pend     = {r_sync[SYNC_STAGES-1], csr_ecl_timer_intr, estat_sis} & {4{resetn}};
    assign w_act      = w_pend & ecfg_lie;
    assign w_any_pend = (|w_act) & csr_ecl_crmd_ie;
    assign w_win      = f_prio(w_act);

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and take decision; a synchronous exception or ertn holds off the take.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_pend) begin
                    w_state_nxt = ST_ARM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (!w_any_pend) begin
                    w_state_nxt = ST_IDLE;
                end else if (except_e || ertn_e || !valid_e) begin
                    w_state_nxt = ST_ARM;
                end else begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_TAKEN;
                end
            end
            ST_TAKEN: begin
                if (!csr_ecl_crmd_ie) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_TAKEN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Winning source captured at the take and held until the next one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_src <= 2'd0;
        end else if (w_take) begin
            r_src <= w_win;
        end else begin
            r_src <= r_src;
        end
    end

    assign intr_take = w_take;
    assign intr_src  = w_take ? w_win : r_src;
    assign intr_pend = w_pend;

endmodule

// File: tb/tb_cpu7_intr_ctl.sv
// Self-checking bench for cpu7_intr_ctl: directed table, hand-written corner
// sequences and randomized traffic against a behavioural reference model.
module tb_cpu7_intr_ctl;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ext_intr = 1'b0;
    logic       timer = 1'b0;
    logic [1:0] sis = 2'b00;
    logic       ie = 1'b0;
    logic [3:0] lie = 4'h0;
    logic       valid_e = 1'b0;
    logic       except_e = 1'b0;
    logic       ertn_e = 1'b0;
    logic       take;
    logic [1:0] src;
    logic [3:0] pend;

    int n_vec = 0;
    int n_err = 0;

    cpu7_intr_ctl #(.SYNC_STAGES(S)) dut (
        .clk(clk), .resetn(resetn), .ext_intr(ext_intr),
        .csr_ecl_timer_intr(timer), .estat_sis(sis),
        .csr_ecl_crmd_ie(ie), .ecfg_lie(lie), .valid_e(valid_e),
        .except_e(except_e), .ertn_e(ertn_e),
        .intr_take(take), .intr_src(src), .intr_pend(pend)
    );

    always #5 clk = ~clk;

    // Reference model: ext arrives through an S-deep delay line; phase 0 = waiting
    // for a request, 1 = request seen and looking for an instruction, 2 = locked out.
    int         ext_line[$];
    int         m_phase;
    logic [1:0] m_src;

    task automatic model_reset();
        ext_line = {};
        repeat (S) ext_line.push_back(0);
        m_phase = 0;
        m_src   = 2'd0;
    endtask

    task automatic model_eval(output logic e_take, output logic [1:0] e_src,
                              output logic [3:0] e_pend, output logic e_want);
        logic [3:0] act;
        logic [1:0] win;
        e_pend = resetn ? {ext_line[0] != 0, timer, sis} : 4'h0;
        act    = e_pend & lie;
        e_want = (act != 4'h0) && ie;
        win    = 2'd0;
        for (int b = 3; b >= 0; b--) begin
            if (act[b]) begin
                win = 2'(b);
                break;
            end
        end
        e_take = (m_phase == 1) && e_want && valid_e && !except_e && !ertn_e;
        e_src  = e_take ? win : m_src;
    endtask

    task automatic chk(input string name, input int act_v, input int exp_v);
        n_vec++;
        if (act_v != exp_v) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act_v, exp_v);
        end
    endtask

    task automatic drive(input logic x, input logic t, input logic [1:0] s, input logic en,
                         input logic [3:0] l, input logic v, input logic ex, input logic er);
        ext_intr = x; timer = t; sis = s; ie = en; lie = l;
        valid_e = v; except_e = ex; ertn_e = er;
        #4;
    endtask

    task automatic check_model();
        logic e_take, e_want;
        logic [1:0] e_src;
        logic [3:0] e_pend;
        model_eval(e_take, e_src, e_pend, e_want);
        chk("model_take", int'(take), int'(e_take));
        chk("model_src", int'(src), int'(e_src));
        chk("model_pend", int'(pend), int'(e_pend));
    endtask

    task automatic tick();
        logic e_take, e_want;
        logic [1:0] e_src;
        logic [3:0] e_pend;
        model_eval(e_take, e_src, e_pend, e_want);
        @(posedge clk);
        ext_line.push_back(int'(ext_intr));
        void'(ext_line.pop_front());
        if (e_take) m_src = e_src;
        case (m_phase)
            0: m_phase = e_want ? 1 : 0;
            1: m_phase = !e_want ? 0 : (e_take ? 2 : 1);
            2: m_phase = ie ? 2 : 0;
            default: m_phase = 0;
        endcase
        #1;
    endtask

    task automatic do_reset();
        ext_intr = 1'b0; timer = 1'b0; sis = 2'b00; ie = 1'b1; lie = 4'hF;
        valid_e = 1'b1; except_e = 1'b0; ertn_e = 1'b0;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("rst_take", int'(take), 0);
        chk("rst_src", int'(src), 0);
        chk("rst_pend", int'(pend), 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    // Per-cycle step driven with the common defaults, checked against the model.
    task automatic step(input logic x, input logic t, input logic [1:0] s, input logic en);
        drive(x, t, s, en, 4'hF, 1'b1, 1'b0, 1'b0);
        check_model();
    endtask

    typedef struct {
        logic       t;
        logic [1:0] s;
        logic       en;
        logic [3:0] l;
        logic       v;
        logic       ex;
        logic       er;
        logic       e_take;
        logic [1:0] e_src;
        logic [3:0] e_pend;
    } vec_t;

    function automatic vec_t mk(input logic t, input logic [1:0] s, input logic en,
                                input logic [3:0] l, input logic v, input logic ex,
                                input logic er, input logic et, input logic [1:0] es,
                                input logic [3:0] ep);
        vec_t r;
        r.t = t; r.s = s; r.en = en; r.l = l; r.v = v; r.ex = ex; r.er = er;
        r.e_take = et; r.e_src = es; r.e_pend = ep;
        return r;
    endfunction

    vec_t tbl[21];

    initial begin
        tbl[0]  = mk(1'b0, 2'b00, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
        tbl[1]  = mk(1'b1, 2'b00, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h4);
        tbl[2]  = mk(1'b1, 2'b00, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'h4);
        tbl[3]  = mk(1'b1, 2'b00, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'h4);
        tbl[4]  = mk(1'b1, 2'b00, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'h4);
        tbl[5]  = mk(1'b0, 2'b00, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'h0);
        tbl[6]  = mk(1'b0, 2'b01, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'h1);
        tbl[7]  = mk(1'b0, 2'b01, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'h1);
        tbl[8]  = mk(1'b0, 2'b01, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'h1);
        tbl[9]  = mk(1'b0, 2'b01, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'h1);
        tbl[10] = mk(1'b0, 2'b01, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h1);
        tbl[11] = mk(1'b0, 2'b01, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h1);
        tbl[12] = mk(1'b0, 2'b01, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h1);
        tbl[13] = mk(1'b1, 2'b00, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h4);
        tbl[14] = mk(1'b0, 2'b00, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
        tbl[15] = mk(1'b0, 2'b00, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
        tbl[16] = mk(1'b0, 2'b11, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h3);
        tbl[17] = mk(1'b0, 2'b11, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h3);
        tbl[18] = mk(1'b1, 2'b11, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'h7);
        tbl[19] = mk(1'b0, 2'b00, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'h0);
        tbl[20] = mk(1'b0, 2'b00, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'h0);

        do_reset();
        for (int i = 0; i < 21; i++) begin
            drive(1'b0, tbl[i].t, tbl[i].s, tbl[i].en, tbl[i].l, tbl[i].v, tbl[i].ex, tbl[i].er);
            check_model();
            chk($sformatf("tbl%0d_take", i), int'(take), int'(tbl[i].e_take));
            chk($sformatf("tbl%0d_src", i), int'(src), int'(tbl[i].e_src));
            chk($sformatf("tbl%0d_pend", i), int'(pend), int'(tbl[i].e_pend));
            tick();
        end

        // ext latency: take in the cycle after edge k+S.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 1'b0, 2'b00, 1'b1);
            chk($sformatf("extlat_c%0d", c), int'(take), (c == S + 1) ? 1 : 0);
            if (c == S + 1) chk("extlat_src", int'(src), 3);
            tick();
        end

        // ext and swi rise together: swi1 first, ext after IE reopens.
        do_reset();
        step(1'b1, 1'b0, 2'b11, 1'b1);
        chk("sim_c0_take", int'(take), 0);
        tick();
        step(1'b1, 1'b0, 2'b11, 1'b1);
        chk("sim_c1_take", int'(take), 1);
        chk("sim_c1_src", int'(src), 1);
        chk("sim_c1_pend", int'(pend), 3);
        tick();
        step(1'b1, 1'b0, 2'b11, 1'b1);
        chk("sim_c2_pend", int'(pend), 11);
        chk("sim_c2_take", int'(take), 0);
        tick();
        step(1'b1, 1'b0, 2'b11, 1'b0);
        tick();
        step(1'b1, 1'b0, 2'b11, 1'b1);
        chk("sim_c4_take", int'(take), 0);
        tick();
        step(1'b1, 1'b0, 2'b11, 1'b1);
        chk("sim_c5_take", int'(take), 1);
        chk("sim_c5_src", int'(src), 3);
        tick();

        // Reset in the take cycle, then normal re-arm.
        do_reset();
        step(1'b0, 1'b1, 2'b00, 1'b1);
        tick();
        step(1'b0, 1'b1, 2'b00, 1'b1);
        chk("rtk_take_before", int'(take), 1);
        resetn = 1'b0;
        model_reset();
        #1;
        chk("rtk_take_async", int'(take), 0);
        chk("rtk_src_async", int'(src), 0);
        chk("rtk_pend_async", int'(pend), 0);
        @(posedge clk);
        #1 resetn = 1'b1;
        step(1'b0, 1'b1, 2'b00, 1'b1);
        chk("rtk_first_after", int'(take), 0);
        tick();
        step(1'b0, 1'b1, 2'b00, 1'b1);
        chk("rtk_retake", int'(take), 1);
        chk("rtk_retake_src", int'(src), 2);
        tick();

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic x, t, en, v, ex, er;
            logic [1:0] s;
            logic [3:0] l;
            x  = ($urandom_range(0, 5) == 0) ? ~ext_intr : ext_intr;
            t  = ($urandom_range(0, 4) == 0) ? ~timer : timer;
            s  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : sis;
            en = ($urandom_range(0, 5) != 0);
            l  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            v  = ($urandom_range(0, 3) != 0);
            ex = ($urandom_range(0, 7) == 0);
            er = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 150) == 0) begin
                do_reset();
            end
            drive(x, t, s, en, l, v, ex, er);
            check_model();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu7_intr_ctl.md
CPU7_INTR_CTL -- requirements
Module: cpu7_intr_ctl

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, default 2, number of synchronizer flops on ext_intr (legal 2..3).
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: resetn  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: ext_intr  input  1  external interrupt level, asynchronous to clk.
REQ-005 SHALL have port: csr_ecl_timer_intr  input  1  timer interrupt level, synchronous.
REQ-006 SHALL have port: estat_sis  input  2  software interrupt levels SWI1/SWI0, synchronous.
REQ-007 SHALL have port: csr_ecl_crmd_ie  input  1  global interrupt enable (CRMD.IE).
REQ-008 SHALL have port: ecfg_lie  input  4  local enables {ext, timer, swi1, swi0}.
REQ-009 SHALL have port: valid_e  input  1  a committable instruction occupies _e this cycle.
REQ-010 SHALL have port: except_e  input  1  synchronous exception being taken at _e.
REQ-011 SHALL have port: ertn_e  input  1  ertn at _e.
REQ-012 SHALL have port: intr_take  output  1  take interrupt on the _e instruction this cycle.
REQ-013 SHALL have port: intr_src  output  2  winning source: 3 ext, 2 timer, 1 swi1, 0 swi0.
REQ-014 SHALL have port: intr_pend  output  4  synchronized raw pending {ext, timer, swi1, swi0}, unmasked.

Function
REQ-015 SHALL pass ext_intr through SYNC_STAGES flops; timer and swi SHALL NOT be synchronized.
REQ-016 SHALL compute act = intr_pend & ecfg_lie and any_pend = |act & csr_ecl_crmd_ie, combinationally.
REQ-017 SHALL implement a 3-state FSM: IDLE, ARM, TAKEN.
REQ-018 IDLE: go to ARM on the next edge when any_pend=1; otherwise stay.
REQ-019 ARM with any_pend=0: return to IDLE, with no take.
REQ-020 ARM with any_pend=1, valid_e=1, except_e=0, ertn_e=0: assert intr_take combinationally in that cycle; go to TAKEN.
REQ-021 ARM with except_e=1 or ertn_e=1: intr_take=0; stay ARM, because the synchronous event wins.
REQ-022 ARM with valid_e=0: stay ARM, with no take.
REQ-023 TAKEN: intr_take=0 and requests are locked out; go to IDLE on the first cycle with csr_ecl_crmd_ie=0.
REQ-024 TAKEN SHALL last at least one cycle.
REQ-025 intr_take SHALL never assert in IDLE or TAKEN, and never on two consecutive cycles.
REQ-026 intr_src SHALL be the fixed-priority winner of act (ext > timer > swi1 > swi0) while intr_take=1.
REQ-027 intr_src SHALL be registered at the take and held constant through TAKEN and until the next take.
REQ-028 Latency, ext: ext_intr high before edge k, valid_e=1, IE=1, lie=all 1 -> intr_take high in the cycle after edge k+SYNC_STAGES.
REQ-029 Latency, timer/swi: source rises in cycle c -> ARM after edge c, intr_take in cycle c+1 if valid_e.
REQ-030 Simultaneous sources SHALL resolve by priority in the take cycle; lower sources stay pending.
REQ-031 A source dropping while in ARM SHALL re-evaluate priority each cycle.
REQ-032 If all sources drop while in ARM, the FSM SHALL return to IDLE with no take.

Reset
REQ-033 resetn low SHALL asynchronously force: FSM IDLE, synchronizer flops 0, intr_src 0, intr_take 0, intr_pend 0.
REQ-034 Reset mid-ARM or mid-TAKEN SHALL discard the pending take; no take in the first cycle after release.

Verification
REQ-035 Reset, IE=1, lie=4'hF, valid_e=1; timer=1 at cycle 5 -> intr_take=1, intr_src=2 in cycle 6 only; TAKEN until IE driven 0; then IDLE.
REQ-036 ext_intr and estat_sis=2'b11 rise together, SYNC_STAGES=2 -> swi1 taken first (src=1); ext pend visible 2 edges later; after IE returns 1, next take has src=3.
REQ-037 ARM with except_e=1 for 3 cycles -> intr_take stays 0; when except_e falls the take occurs in that cycle (IE still 1).
REQ-038 Pending with IE=0 or lie bit 0 -> FSM stays IDLE and intr_take=0; intr_pend shows the raw bit.
REQ-039 Timer pulse high for 1 cycle during ARM with valid_e=0 -> ARM returns to IDLE; no take.
REQ-040 resetn asserted in the take cycle -> outputs 0 immediately; after release with the source still high, re-arm and take with normal latency.
